mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the pipelined MIPS core. It sits beside the ALU in the E stage and accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per start pulse. It holds the HI/LO architectural registers and asserts `busy` for the fixed operation latency. Hazard logic in D stage consumes `start`/`busy` to stall later HI/LO-related instructions.

---
 rtl/mdu_sequencer_pkg.sv | 28 ++
 rtl/mdu_calc.sv | 56 +++++
 rtl/mdu_sequencer.sv | 103 ++++++++++
 tb/tb_mdu_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU definitions: mdop codes, default latencies, bundle types.
// The divider is built only when MDU_DIV_EN is defined; it is off by default.
package mdu_sequencer_pkg;

  typedef enum logic [2:0] {
    MD_none  = 3'd0,
    MD_mult  = 3'd1,
    MD_multu = 3'd2,
    MD_div   = 3'd3,
    MD_divu  = 3'd4,
    MD_mthi  = 3'd5,
    MD_mtlo  = 3'd6
  } mdop_e;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/mdu_calc.sv
// Combinational 32x32 multiply and divide/remainder producing {hi,lo}.
// Divider present only when MDU_DIV_EN is defined.
module mdu_calc
  import mdu_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output hilo_t       res
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic signed [63:0] ps;
  logic        [63:0] pu;

  assign sa = {{32{a[31]}}, a};
  assign sb = {{32{b[31]}}, b};
  assign ps = sa * sb;
  assign pu = {32'b0, a} * {32'b0, b};

`ifdef MDU_DIV_EN
  logic signed [31:0] qs;
  logic signed [31:0] rs;
  logic        [31:0] qu;
  logic        [31:0] ru;

  // Zero divisor yields zeros; the sequencer never commits that case.
  always_comb begin
    qs = '0;
    rs = '0;
    qu = '0;
    ru = '0;
    if (b != '0) begin
      qs = $signed(a) / $signed(b);
      rs = $signed(a) % $signed(b);
      qu = a / b;
      ru = a % b;
    end
  end
`endif

  always_comb begin
    res = '0;
    unique case (op)
      MD_mult:  res = hilo_t'(ps);
      MD_multu: res = hilo_t'(pu);
`ifdef MDU_DIV_EN
      MD_div:   res = {rs, qs};
      MD_divu:  res = {ru, qu};
`endif
      default:  ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multi-cycle MDU sequencer holding HI/LO; busy for fixed latency.
// DIV/DIVU exist only when MDU_DIV_EN is defined, else they act as MD_none.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt, cnt_n;
  hilo_t         res, res_n;
  hilo_t         arch, arch_n;
  logic          wr, wr_n;
  hilo_t         calc;
  state_e        state;
  logic          is_mul, is_div, is_mthi, is_mtlo;

  mdu_calc u_calc (
    .op  (mdop),
    .a   (a),
    .b   (b),
    .res (calc)
  );

  assign is_mul  = (mdop == MD_mult) || (mdop == MD_multu);
  assign is_mthi = (mdop == MD_mthi);
  assign is_mtlo = (mdop == MD_mtlo);
`ifdef MDU_DIV_EN
  assign is_div  = (mdop == MD_div) || (mdop == MD_divu);
`else
  assign is_div  = 1'b0;
`endif

  assign state = (cnt == '0) ? IDLE : RUN;
  assign busy  = (state == RUN);
  assign hi    = arch.hi;
  assign lo    = arch.lo;

  always_comb begin
    cnt_n  = cnt;
    res_n  = res;
    arch_n = arch;
    wr_n   = wr;
    case (state)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul: begin
              res_n = calc;
              wr_n  = 1'b1;
              cnt_n = CW'(MULT_LAT);
            end
            is_div: begin
              // Divide by zero runs full length but never commits.
              res_n = calc;
              wr_n  = (b != '0);
              cnt_n = CW'(DIV_LAT);
            end
            is_mthi: arch_n.hi = a;
            is_mtlo: arch_n.lo = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          if (wr) arch_n = res;
          wr_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      res  <= '0;
      arch <= '0;
      wr   <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      res  <= res_n;
      arch <= arch_n;
      wr   <= wr_n;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: random and directed ops vs. an
// arithmetic reference model; build with or without MDU_DIV_EN.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mdop = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mdu_sequencer #(
    .MULT_LAT (ML),
    .DIV_LAT  (DL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdop  (mdop),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // lat: expected busy cycles; -1 marks an op aborted by reset
  typedef struct {
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic void check(input string name,
                                input logic [64:0] act,
                                input logic [64:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  task automatic model_op(input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, output int lat);
    longint sx, sy, p, q, r;
    longint unsigned ux, uy, pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    lat = 0;
    case (op)
      3'd1: begin
        p = sx * sy;
        m_hi = p[63:32];
        m_lo = p[31:0];
        lat = ML;
      end
      3'd2: begin
        pu = ux * uy;
        m_hi = pu[63:32];
        m_lo = pu[31:0];
        lat = ML;
      end
      3'd3, 3'd4: begin
        if (DIV_ON) begin
          lat = DL;
          if (y != 0) begin
            if (op == 3'd3) begin
              q = sx / sy;
              r = sx % sy;
            end else begin
              q = longint'(ux / uy);
              r = longint'(ux % uy);
            end
            m_lo = q[31:0];
            m_hi = r[31:0];
          end
        end
      end
      3'd5: m_hi = x;
      3'd6: m_lo = x;
      default: ;
    endcase
  endtask

  // Issue one op; optionally poke an illegal mtlo while busy.
  task automatic issue(input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input bit poke);
    int lat;
    model_op(op, x, y, lat);
    sbq.push_back('{lat, m_hi, m_lo});
    @(negedge clk);
    #1;
    start = 1'b1;
    mdop = op;
    a = x;
    b = y;
    @(negedge clk);
    #1;
    start = 1'b0;
    mdop = '0;
    a = $urandom;
    b = $urandom;
    if (poke && lat >= 3) begin
      @(negedge clk);
      #1;
      start = 1'b1;
      mdop = MD_mtlo;
      a = 32'hDEAD_BEEF;
      @(negedge clk);
      #1;
      start = 1'b0;
      mdop = '0;
      repeat (lat - 3) @(negedge clk);
    end else if (lat > 1) begin
      repeat (lat - 1) @(negedge clk);
    end
  endtask

  // Monitor: pops expectations whenever the DUT accepts a start.
  initial begin : monitor
    logic        bp;
    logic [31:0] lh, ll;
    exp_t        e;
    int          n;
    bp = 1'b0;
    lh = '0;
    ll = '0;
    forever begin
      @(negedge clk);
      if (reset && start && !bp) begin
        if (sbq.size() == 0) begin
          check("unexpected_accept", 65'd1, 65'd0);
        end else begin
          e = sbq.pop_front();
          if (e.lat == 0) begin
            check("nolat_result", {busy, hi, lo}, {1'b0, e.hi, e.lo});
          end else begin
            n = 0;
            while (busy && n < 64) begin
              check("hold_while_busy", {1'b0, hi, lo}, {1'b0, lh, ll});
              n++;
              @(negedge clk);
            end
            if (e.lat < 0) begin
              check("abort_clear", {busy, hi, lo}, 65'd0);
            end else begin
              check("busy_cycles", 65'(n), 65'(e.lat));
              check("commit", {busy, hi, lo}, {1'b0, e.hi, e.lo});
            end
          end
          lh = hi;
          ll = lo;
        end
      end else if (reset) begin
        check("idle_stable", {busy, hi, lo}, {1'b0, lh, ll});
      end
      bp = busy;
    end
  end

  initial begin : stim
    logic [2:0]  op;
    logic [31:0] x, y;
    bit          pk;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, hi, lo}, 65'd0);
    #1;
    reset = 1'b1;

    issue(MD_mult, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue(MD_multu, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(MD_div, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(MD_divu, 32'd7, 32'd2, 1'b0);
    issue(MD_mtlo, 32'h0000_1234, 32'd0, 1'b0);
    issue(MD_div, 32'd5, 32'd0, 1'b0);
    issue(MD_mthi, 32'h0000_ABCD, 32'd0, 1'b0);
    issue(MD_mult, 32'd1234, 32'd5678, 1'b1);
    issue(MD_multu, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(3'd7, 32'h1111_1111, 32'd1, 1'b0);
    issue(MD_none, 32'h2222_2222, 32'd1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'd3;
      pk = ($urandom_range(0, 3) == 0);
      issue(op, x, y, pk);
    end

    // Reset in the third busy cycle aborts without a later commit.
    issue(MD_mthi, 32'h5555_0001, 32'd0, 1'b0);
    issue(MD_mtlo, 32'h5555_0002, 32'd0, 1'b0);
    sbq.push_back('{-1, 32'd0, 32'd0});
    @(negedge clk);
    #1;
    start = 1'b1;
    mdop = DIV_ON ? MD_div : MD_mult;
    a = 32'd100;
    b = 32'd7;
    @(negedge clk);
    #1;
    start = 1'b0;
    mdop = '0;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (DL + 3) @(negedge clk);
    issue(MD_mult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    repeat (DL + 5) @(negedge clk);
    check("queue_drained", 65'(sbq.size()), 65'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
